// File: rtl/exa_crosb_out_arb_if.sv
// ---------------------------------------------------------------------------
// exa_crosb_out_arb_if
//
// Purpose:
//   Bundles every signal between one crossbar output-port arbiter and its
//   surroundings: the per-input demux side (beats coming in), the downstream
//   output-port side (registered beats going out) and the status outputs.
//   Clock and reset are plain ports on the arbiter and are not part of this
//   bundle.
//
// Handshake (valid/ready, both sides):
//   A beat moves across a channel on a rising clock edge where valid and
//   ready are both 1. The producer holds data/last/prio stable while valid
//   is 1 and ready is 0. On the input side, ready is a pure function of
//   arbiter state and downstream ready and never looks at valid.
//
// Signals:
//   DATA_i    [input_num][data_width]  beat from each input's demux
//   VALID_i   [input_num]              per-input beat valid
//   LAST_i    [input_num]              per-input end-of-packet
//   PRIO_i    [input_num]              per-input packet priority
//   READY_o   [input_num]              per-input accept, one-hot or zero
//   DATA_o    [data_width]             registered output beat
//   VALID_o                            output beat valid
//   LAST_o                             output end-of-packet
//   PRIO_o                             output packet priority
//   READY_i                            downstream accept
//   GRANT_o   [sel_width]              locked input index (valid while BUSY_o)
//   BUSY_o                             a packet is locked
//   STATE_o                            FSM state, 0 = IDLE, 1 = LOCK
//   PKT_CNT_o [32]                     only with EXA_CROSB_OUT_ARB_STATS_EN
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (demuxes, downstream port, monitors)
//
// Optional feature macro: EXA_CROSB_OUT_ARB_STATS_EN
// ---------------------------------------------------------------------------
interface exa_crosb_out_arb_if #(
   parameter int data_width = 128,
   parameter int input_num  = 16,
   parameter int sel_width  = (input_num > 1) ? $clog2(input_num) : 1
);
   logic [input_num-1:0][data_width-1:0] DATA_i;
   logic [input_num-1:0]                 VALID_i;
   logic [input_num-1:0]                 LAST_i;
   logic [input_num-1:0]                 PRIO_i;
   logic [input_num-1:0]                 READY_o;

   logic [data_width-1:0]                DATA_o;
   logic                                 VALID_o;
   logic                                 LAST_o;
   logic                                 PRIO_o;
   logic                                 READY_i;

   logic [sel_width-1:0]                 GRANT_o;
   logic                                 BUSY_o;
   logic                                 STATE_o;
`ifdef EXA_CROSB_OUT_ARB_STATS_EN
   logic [31:0]                          PKT_CNT_o;
`endif

   modport slave (
      input  DATA_i, VALID_i, LAST_i, PRIO_i, READY_i,
      output READY_o, DATA_o, VALID_o, LAST_o, PRIO_o,
      output GRANT_o, BUSY_o, STATE_o
`ifdef EXA_CROSB_OUT_ARB_STATS_EN
      , output PKT_CNT_o
`endif
   );

   modport master (
      output DATA_i, VALID_i, LAST_i, PRIO_i, READY_i,
      input  READY_o, DATA_o, VALID_o, LAST_o, PRIO_o,
      input  GRANT_o, BUSY_o, STATE_o
`ifdef EXA_CROSB_OUT_ARB_STATS_EN
      , input PKT_CNT_o
`endif
   );
endinterface

// File: rtl/exa_crosb_out_arb.sv
// ---------------------------------------------------------------------------
// exa_crosb_out_arb
//
// Purpose:
//   Output-port arbiter of the crossbar. One instance per output port, fed
//   by output j of every input's demux. It picks one requesting input per
//   packet (PRIO=1 class first, round-robin inside each class), holds that
//   grant until the LAST beat has been accepted, and forwards the packet's
//   beats through a single-entry output register.
//
// Ports:
//   CLK_i   in  clock
//   RST_i   in  synchronous active-high reset
//   bus     exa_crosb_out_arb_if.slave - input beats, output beats,
//           grant/busy status, debug state and (optionally) packet count
//
// Timing:
//   IDLE cycle with any VALID_i -> grant registered, no beat accepted.
//   LOCK: a beat accepted on edge N appears on DATA_o/VALID_o after edge N.
//
// Optional feature macro: EXA_CROSB_OUT_ARB_STATS_EN
//   When defined, PKT_CNT_o counts output transfers carrying LAST_o=1,
//   saturating at 32'hFFFF_FFFF. When undefined, neither port nor counter
//   exists and all other behaviour is unchanged.
// ---------------------------------------------------------------------------
module exa_crosb_out_arb #(
   parameter int data_width = 128,
   parameter int input_num  = 16,
   parameter int sel_width  = (input_num > 1) ? $clog2(input_num) : 1
) (
   input  logic                   CLK_i,
   input  logic                   RST_i,
   exa_crosb_out_arb_if.slave     bus
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [sel_width-1:0]   grant_q, grant_d;
   logic [sel_width-1:0]   hp_ptr_q, hp_ptr_d;
   logic [sel_width-1:0]   lp_ptr_q, lp_ptr_d;
   // first_q marks that the next accepted beat is the packet's first beat;
   // pkt_prio_q keeps the priority sampled with that first beat.
   logic                   first_q, first_d;
   logic                   pkt_prio_q, pkt_prio_d;

   logic [data_width-1:0]  data_q;
   logic                   valid_q;
   logic                   last_q;
   logic                   prio_q;

   logic                   load;
   logic                   accept;
   logic                   beat_prio;
   logic                   beat_last;
   logic [input_num-1:0]   ready;

   // arbitration helpers
   logic [input_num-1:0]   hp_req;
   logic                   use_hp;
   logic [input_num-1:0]   cand;
   logic [sel_width-1:0]   scan_start;
   logic [input_num-1:0]   rot;
   logic                   win_found;
   int                     win_off;
   int                     win_sum;
   logic [sel_width-1:0]   win_idx;

   // Next round-robin position after index p, wrapping input_num-1 -> 0
   // (input_num need not be a power of two).
   function automatic logic [sel_width-1:0] wrap_inc(input logic [sel_width-1:0] p);
      if (p == sel_width'(input_num - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // -------------------------------------------------------------------------
   // Handshake
   // -------------------------------------------------------------------------
   // The output register can take a beat when it is empty or draining now.
   assign load   = !valid_q | bus.READY_i;
   assign accept = (state_q == LOCK) & load & bus.VALID_i[grant_q];

   always_comb begin
      ready = '0;
      if ((state_q == LOCK) && load) begin
         ready[grant_q] = 1'b1;
      end
   end

   assign beat_last = bus.LAST_i[grant_q];
   // Priority is a packet attribute: taken live on the first beat, then held.
   assign beat_prio = first_q ? bus.PRIO_i[grant_q] : pkt_prio_q;

   // -------------------------------------------------------------------------
   // Winner search
   // -------------------------------------------------------------------------
   // The candidate vector is rotated so that bit 0 is the class pointer; the
   // lowest set bit of the rotated vector is then the first requester at or
   // after the pointer. Doubling the vector before shifting makes the
   // rotation correct for any input_num.
   always_comb begin
      hp_req     = bus.VALID_i & bus.PRIO_i;
      use_hp     = |hp_req;
      cand       = use_hp ? hp_req : bus.VALID_i;
      scan_start = use_hp ? hp_ptr_q : lp_ptr_q;
      rot        = input_num'({cand, cand} >> scan_start);
      win_found  = 1'b0;
      win_off    = 0;
      for (int i = input_num - 1; i >= 0; i--) begin
         if (rot[i]) begin
            win_found = 1'b1;
            win_off   = i;
         end
      end
      win_sum = int'(scan_start) + win_off;
      if (win_sum >= input_num) begin
         win_sum = win_sum - input_num;
      end
      win_idx = sel_width'(win_sum);
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         hp_ptr_q   <= '0;
         lp_ptr_q   <= '0;
         first_q    <= 1'b0;
         pkt_prio_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         hp_ptr_q   <= hp_ptr_d;
         lp_ptr_q   <= lp_ptr_d;
         first_q    <= first_d;
         pkt_prio_q <= pkt_prio_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      hp_ptr_d   = hp_ptr_q;
      lp_ptr_d   = lp_ptr_q;
      first_d    = first_q;
      pkt_prio_d = pkt_prio_q;
      case (state_q)
         IDLE: begin
            // Arbitration cycle only; the first beat is taken next cycle.
            if (win_found) begin
               grant_d = win_idx;
               first_d = 1'b1;
               state_d = LOCK;
            end
         end
         LOCK: begin
            if (accept) begin
               first_d    = 1'b0;
               pkt_prio_d = beat_prio;
               if (beat_last) begin
                  state_d = IDLE;
                  if (beat_prio) begin
                     hp_ptr_d = wrap_inc(grant_q);
                  end else begin
                     lp_ptr_d = wrap_inc(grant_q);
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         prio_q  <= 1'b0;
      end else if (accept) begin
         data_q  <= bus.DATA_i[grant_q];
         valid_q <= 1'b1;
         last_q  <= beat_last;
         prio_q  <= beat_prio;
      end else if (bus.READY_i) begin
         // Drained with nothing behind it; payload is left as-is.
         valid_q <= 1'b0;
      end
   end

`ifdef EXA_CROSB_OUT_ARB_STATS_EN
   // -------------------------------------------------------------------------
   // Completed-packet counter (saturating)
   // -------------------------------------------------------------------------
   logic [31:0] pkt_cnt_q;

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         pkt_cnt_q <= '0;
      end else if (valid_q && bus.READY_i && last_q && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
         pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
   end

   assign bus.PKT_CNT_o = pkt_cnt_q;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.READY_o = ready;
   assign bus.DATA_o  = data_q;
   assign bus.VALID_o = valid_q;
   assign bus.LAST_o  = last_q;
   assign bus.PRIO_o  = prio_q;
   assign bus.GRANT_o = grant_q;
   assign bus.BUSY_o  = (state_q == LOCK);
   assign bus.STATE_o = logic'(state_q);

endmodule

// File: tb/tb_exa_crosb_out_arb.sv
// ---------------------------------------------------------------------------
// tb_exa_crosb_out_arb
//
// Purpose:
//   Self-checking bench for exa_crosb_out_arb. Each input owns a queue of
//   pending beats {last, prio, data}. A per-cycle step drives the head beat
//   of each queue, observes handshakes, and keeps a transaction-level model:
//   whenever the arbiter is idle with requesters, the model picks the winner
//   from the class/pointer rules and appends that whole packet to the
//   expected output queue, which every output transfer is compared against.
// ---------------------------------------------------------------------------
module tb_exa_crosb_out_arb;

   localparam int DW = 128;
   localparam int N  = 16;
   localparam int SW = 4;
   localparam int EW = DW + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   exa_crosb_out_arb_if #(.data_width(DW), .input_num(N)) bus();

   exa_crosb_out_arb #(.data_width(DW), .input_num(N)) dut (
      .CLK_i (clk),
      .RST_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] in_q [N][$];
   logic [EW-1:0] exp_q [$];
   int            grant_log [$];
   logic [N-1:0]  hist_ready [$];
   logic          hist_valid_o [$];
   logic          hist_last_o [$];
   logic          hist_busy [$];

   int mdl_hp;
   int mdl_lp;
   bit gap_en;
   bit ready_rand;
   bit ready_force0;
   int out_cnt;

   // ------------------------------------------------------------------------
   // Reference model helpers
   // ------------------------------------------------------------------------
   function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] p);
      logic [N-1:0] hp;
      hp = v & p;
      if (hp != '0) begin
         for (int i = 0; i < N; i++) begin
            if (hp[(mdl_hp + i) % N]) return (mdl_hp + i) % N;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (v[(mdl_lp + i) % N]) return (mdl_lp + i) % N;
      end
      return -1;
   endfunction

   function automatic bit inputs_pending();
      for (int k = 0; k < N; k++) begin
         if (in_q[k].size() > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic add_packet(input int k, input int len, input bit prio);
      logic [DW-1:0] d;
      for (int b = 0; b < len; b++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         in_q[k].push_back({(b == len - 1), prio, d});
      end
   endtask

   // ------------------------------------------------------------------------
   // Driver / monitor: one clock cycle, entered and left at a negedge
   // ------------------------------------------------------------------------
   task automatic step();
      logic [N-1:0]         v, l, p, in_acc, exp_rdy;
      logic [N-1:0][DW-1:0] d;
      logic                 idle_pre, out_acc;
      logic [EW-1:0]        out_beat, e;
      int                   w;
      v = '0; l = '0; p = '0; d = '0;
      for (int k = 0; k < N; k++) begin
         if (in_q[k].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            v[k] = 1'b1;
            {l[k], p[k], d[k]} = in_q[k][0];
         end
      end
      bus.VALID_i = v;
      bus.LAST_i  = l;
      bus.PRIO_i  = p;
      bus.DATA_i  = d;
      bus.READY_i = ready_force0 ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      hist_ready.push_back(bus.READY_o);
      hist_valid_o.push_back(bus.VALID_o);
      hist_last_o.push_back(bus.LAST_o);
      hist_busy.push_back(bus.BUSY_o);
      exp_rdy = '0;
      if (bus.BUSY_o && (!bus.VALID_o || bus.READY_i)) exp_rdy[bus.GRANT_o] = 1'b1;
      checks++;
      if (bus.READY_o !== exp_rdy) begin
         errors++;
         $display("FAIL ready_o: got %h want %h", bus.READY_o, exp_rdy);
      end
      idle_pre = (bus.BUSY_o === 1'b0);
      w        = idle_pre ? pick(v, p) : -1;
      in_acc   = bus.VALID_i & bus.READY_o;
      out_acc  = bus.VALID_o & bus.READY_i;
      out_beat = {bus.LAST_o, bus.PRIO_o, bus.DATA_o};
      @(posedge clk);
      @(negedge clk);
      if (out_acc === 1'b1) begin
         out_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_beat: got unexpected beat %h want none", out_beat);
         end else begin
            e = exp_q.pop_front();
            if (out_beat !== e) begin
               errors++;
               $display("FAIL out_beat: got %h want %h", out_beat, e);
            end
         end
      end
      for (int k = 0; k < N; k++) begin
         if (in_acc[k] === 1'b1 && in_q[k].size() > 0) void'(in_q[k].pop_front());
      end
      if (w >= 0) begin
         checks++;
         if (bus.BUSY_o !== 1'b1 || bus.GRANT_o !== w[SW-1:0]) begin
            errors++;
            $display("FAIL arbitrate: got busy=%b grant=%0d want busy=1 grant=%0d",
                     bus.BUSY_o, bus.GRANT_o, w);
         end
         grant_log.push_back(w);
         for (int b = 0; b < in_q[w].size(); b++) begin
            exp_q.push_back(in_q[w][b]);
            if (in_q[w][b][EW-1]) break;
         end
         if (in_q[w][0][EW-2]) mdl_hp = (w + 1) % N;
         else                  mdl_lp = (w + 1) % N;
      end else if (idle_pre) begin
         checks++;
         if (bus.BUSY_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b want busy=0", bus.BUSY_o);
         end
      end
   endtask

   task automatic drain(input int max_cyc);
      int c;
      c = 0;
      while ((inputs_pending() || exp_q.size() > 0 || bus.VALID_o === 1'b1) && c < max_cyc) begin
         step();
         c++;
      end
      checks++;
      if (c >= max_cyc) begin
         errors++;
         $display("FAIL drain: got timeout after %0d cycles want empty (exp_q=%0d)", c, exp_q.size());
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < N; k++) in_q[k].delete();
      exp_q.delete();
      grant_log.delete();
      hist_ready.delete();
      hist_valid_o.delete();
      hist_last_o.delete();
      hist_busy.delete();
      mdl_hp       = 0;
      mdl_lp       = 0;
      gap_en       = 1'b0;
      ready_rand   = 1'b0;
      ready_force0 = 1'b0;
      out_cnt      = 0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.VALID_i = '0;
      bus.LAST_i  = '0;
      bus.PRIO_i  = '0;
      bus.DATA_i  = '0;
      bus.READY_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.VALID_o !== 1'b0 || bus.LAST_o !== 1'b0 || bus.PRIO_o !== 1'b0 ||
          bus.BUSY_o !== 1'b0 || bus.STATE_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got v=%b l=%b p=%b busy=%b st=%b want all 0",
                  bus.VALID_o, bus.LAST_o, bus.PRIO_o, bus.BUSY_o, bus.STATE_o);
      end
      checks++;
      if (bus.DATA_o !== '0 || bus.GRANT_o !== '0 || bus.READY_o !== '0) begin
         errors++;
         $display("FAIL reset_bus: got data=%h grant=%0d ready=%h want 0", bus.DATA_o, bus.GRANT_o,
                  bus.READY_o);
      end
`ifdef EXA_CROSB_OUT_ARB_STATS_EN
      checks++;
      if (bus.PKT_CNT_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d want 0", bus.PKT_CNT_o);
      end
`endif
   endtask

   task automatic test_single_packet();
      logic [N-1:0] rdy_e [6];
      logic         busy_e [6];
      logic         vo_e [6];
      logic         lo_e [6];
      rdy_e  = '{16'h0, 16'h1, 16'h1, 16'h1, 16'h0, 16'h0};
      busy_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vo_e   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      lo_e   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      add_packet(0, 3, 1'b0);
      repeat (6) step();
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (hist_ready[c] !== rdy_e[c] || hist_busy[c] !== busy_e[c] || hist_valid_o[c] !== vo_e[c]) begin
            errors++;
            $display("FAIL single_timing c%0d: got rdy=%h busy=%b vo=%b want rdy=%h busy=%b vo=%b",
                     c, hist_ready[c], hist_busy[c], hist_valid_o[c], rdy_e[c], busy_e[c], vo_e[c]);
         end
         if (vo_e[c]) begin
            checks++;
            if (hist_last_o[c] !== lo_e[c]) begin
               errors++;
               $display("FAIL single_last c%0d: got %b want %b", c, hist_last_o[c], lo_e[c]);
            end
         end
      end
      drain(20);
   endtask

   task automatic test_round_robin();
      int order [4];
      order = '{2, 5, 2, 5};
      do_reset();
      add_packet(2, 2, 1'b0);
      add_packet(2, 2, 1'b0);
      add_packet(5, 2, 1'b0);
      add_packet(5, 2, 1'b0);
      drain(100);
      checks++;
      if (grant_log.size() != 4) begin
         errors++;
         $display("FAIL rr_count: got %0d grants want 4", grant_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_log[i] != order[i]) begin
               errors++;
               $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[i], order[i]);
            end
         end
      end
   endtask

   task automatic test_priority();
      int  order [3];
      bit  injected;
      int  c;
      order    = '{9, 3, 1};
      injected = 1'b0;
      do_reset();
      add_packet(3, 4, 1'b0);
      add_packet(9, 2, 1'b1);
      c = 0;
      while ((inputs_pending() || exp_q.size() > 0 || bus.VALID_o === 1'b1) && c < 200) begin
         step();
         c++;
         if (!injected && bus.BUSY_o === 1'b1 && bus.GRANT_o === 4'd3 &&
             in_q[3].size() > 0 && in_q[3].size() < 4) begin
            add_packet(1, 2, 1'b1);
            injected = 1'b1;
         end
      end
      checks++;
      if (c >= 200 || !injected || grant_log.size() != 3) begin
         errors++;
         $display("FAIL prio_run: got cycles=%0d injected=%0b grants=%0d want <200 1 3",
                  c, injected, grant_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (grant_log[i] != order[i]) begin
               errors++;
               $display("FAIL prio_order[%0d]: got %0d want %0d", i, grant_log[i], order[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] held_d;
      logic          held_l;
      int            c;
      do_reset();
      add_packet(6, 6, 1'b0);
      c = 0;
      while (!(bus.VALID_o === 1'b1 && in_q[6].size() <= 3) && c < 50) begin
         step();
         c++;
      end
      held_d       = bus.DATA_o;
      held_l       = bus.LAST_o;
      ready_force0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus.DATA_o !== held_d || bus.LAST_o !== held_l || bus.VALID_o !== 1'b1 ||
             bus.READY_o !== '0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got d=%h l=%b v=%b rdy=%h want d=%h l=%b v=1 rdy=0",
                     i, bus.DATA_o, bus.LAST_o, bus.VALID_o, bus.READY_o, held_d, held_l);
         end
      end
      ready_force0 = 1'b0;
      drain(100);
      checks++;
      if (out_cnt != 6) begin
         errors++;
         $display("FAIL stall_beats: got %0d want 6", out_cnt);
      end
   endtask

   task automatic test_reset_mid_packet();
      int c;
      do_reset();
      add_packet(4, 4, 1'b0);
      c = 0;
      while (in_q[4].size() > 2 && c < 50) begin
         step();
         c++;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.VALID_o !== 1'b0 || bus.BUSY_o !== 1'b0 || bus.STATE_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got v=%b busy=%b st=%b want 0 0 0", bus.VALID_o, bus.BUSY_o,
                  bus.STATE_o);
      end
      clear_model();
      add_packet(7, 3, 1'b1);
      drain(50);
      checks++;
      if (grant_log.size() != 1 || out_cnt != 3) begin
         errors++;
         $display("FAIL rst_fresh: got grants=%0d beats=%0d want 1 3", grant_log.size(), out_cnt);
      end else begin
         checks++;
         if (grant_log[0] != 7) begin
            errors++;
            $display("FAIL rst_fresh_grant: got %0d want 7", grant_log[0]);
         end
      end
   endtask

   task automatic test_random();
      int total;
      do_reset();
      gap_en     = 1'b1;
      ready_rand = 1'b1;
      total      = 0;
      for (int i = 0; i < 40; i++) begin
         int len;
         len = $urandom_range(1, 4);
         add_packet($urandom_range(0, N - 1), len, 1'($urandom_range(0, 1)));
         total += len;
      end
      drain(5000);
      checks++;
      if (out_cnt != total) begin
         errors++;
         $display("FAIL random_beats: got %0d want %0d", out_cnt, total);
      end
      gap_en     = 1'b0;
      ready_rand = 1'b0;
   endtask

`ifdef EXA_CROSB_OUT_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 5; i++) add_packet($urandom_range(0, N - 1), $urandom_range(1, 3), 1'b0);
      drain(500);
      checks++;
      if (bus.PKT_CNT_o !== 32'd5) begin
         errors++;
         $display("FAIL stats_count: got %0d want 5", bus.PKT_CNT_o);
      end
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.pkt_cnt_q;
      add_packet(11, 2, 1'b1);
      drain(100);
      checks++;
      if (bus.PKT_CNT_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL stats_sat: got %h want ffffffff", bus.PKT_CNT_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_priority();
      test_stall();
      test_reset_mid_packet();
      test_random();
`ifdef EXA_CROSB_OUT_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
